crack_sched: RTL
================

Name: crack_sched

Overview:
- Top-level key-search scheduler. Splits the 24-bit ARC4 key space across NUM_ENG identical crack engines.
- Engine i tests keys i, i+NUM_ENG, i+2*NUM_ENG, and so on.
- Launches all engines with one en pulse, then monitors each engine's rdy/key_valid to detect completion.
- Returns the first valid key to the host over an en/rdy handshake. Sits between the host/top-level and the crack engine array; the engines share the ct memory externally.

Parameters:
- NUM_ENG, 2, number of crack engines (1..8).
- START_WAIT, 4, cycles after launch within which an engine must deassert eng_rdy before it is declared failed.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  host start request; sampled only while rdy=1
- rdy  out  1  scheduler idle and ready to accept en
- key  out  24  key found by the most recent run
- key_valid  out  1  most recent run found a key
- err  out  1  one or more engines failed to start in the most recent run
- cycles  out  32  RUN-state cycle count of the most recent run, saturating
- eng_en  out  NUM_ENG  per-engine start pulse
- eng_base  out  NUM_ENG*24  starting key of engine i, in bits [24i+23:24i]
- eng_stride  out  24  key increment, constant NUM_ENG
- eng_rdy  in  NUM_ENG  per-engine ready
- eng_key_valid  in  NUM_ENG  per-engine key-found flag
- eng_key  in  NUM_ENG*24  per-engine found key

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE, rdy=1, key=0, key_valid=0, err=0, cycles=0, eng_en=0, and all started/finished flags cleared. Reset mid-run abandons the run. Engines are reset by their own rst_n.
- eng_base[i] = i, held constant. eng_stride = NUM_ENG, held constant.
- IDLE:
  - rdy=1.
  - en=1 at a posedge moves the FSM to DRAIN. rdy drops in the same cycle. key_valid, err and cycles clear to 0.
- DRAIN:
  - Waits until every eng_rdy=1. Engines left running by a previous early exit must finish first.
  - Then moves to LAUNCH.
- LAUNCH:
  - eng_en is all-ones for exactly one cycle.
  - Loads a start-wait counter with START_WAIT.
  - Moves to RUN.
- RUN:
  - cycles increments every RUN cycle, saturating at 32'hFFFF_FFFF.
  - started[i] sets when eng_rdy[i]=0 is observed.
  - finished[i] sets when eng_rdy[i]=1 is observed while started[i]=1.
  - Start-wait counter decrements each cycle. On reaching 0, any engine with started[i]=0 gets finished[i]=1 and err=1.
  - Finish with eng_key_valid[i]=1: capture key=eng_key[i], set key_valid=1, move to IDLE on the next edge. Remaining engines are left running and handled by DRAIN on the next run.
  - Several engines finishing with key_valid in the same cycle: the lowest index wins.
  - All finished with no key_valid: key=0, key_valid=0, move to IDLE.
  - A single engine finishing and the start-wait timeout in the same cycle: the finish is evaluated first.
- Outputs key, key_valid, err and cycles hold their values in IDLE until the next accepted en.
- en while rdy=0 is ignored.
- Latency:
  - en to eng_en takes 2 cycles when all engines are idle.
  - An engine finishing with key_valid produces rdy=1 with key/key_valid on the following cycle.

Test Plan:
- NUM_ENG=2 engine models. Engine 1 finds 24'h00_0003 after 50 cycles; engine 0 exhausts its range after 200 cycles. Pulse en -> eng_en=2'b11 two cycles after en; key=24'h000003, key_valid=1, rdy=1, err=0, cycles≈51.
- Both engines finish in the same cycle with valid keys 24'h000010 (eng0) and 24'h000011 (eng1) -> key=24'h000010.
- No engine finds a key; both finish after 100 cycles -> key_valid=0, key=0, rdy=1.
- Engine 1 never drops eng_rdy -> after START_WAIT=4 cycles err=1. The run completes from engine 0's result alone.
- Run 1 ends early with engine 0 still busy. Issue en again -> FSM holds in DRAIN with eng_en=0 until eng_rdy[0]=1, then launches. key_valid is 0 while run 2 is in progress.
- Assert rst_n=0 for one cycle during RUN -> next cycle rdy=1, key_valid=0, cycles=0, eng_en=0. en held while rdy=0 has no effect.

Source files
------------

// File: rtl/crack_sched.sv
// crack_sched: splits the 24-bit key space over NUM_ENG crack engines,
// launches them together and returns the first key found to the host.
//
// Handshakes:
//   host   - rdy=1 means idle; en is sampled only on a posedge with rdy=1 and
//            starts a run. rdy returns to 1 when the run ends; key, key_valid,
//            err and cycles then hold until the next accepted en.
//   engine - eng_en is a one-cycle start pulse to all engines. An engine is
//            busy while eng_rdy=0; when eng_rdy returns to 1 its
//            eng_key_valid/eng_key describe the result of that run.
module crack_sched #(
  parameter int NUM_ENG    = 2,
  parameter int START_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  output logic [23:0]           key,
  output logic                  key_valid,
  output logic                  err,
  output logic [31:0]           cycles,
  output logic [NUM_ENG-1:0]    eng_en,
  output logic [NUM_ENG*24-1:0] eng_base,
  output logic [23:0]           eng_stride,
  input  logic [NUM_ENG-1:0]    eng_rdy,
  input  logic [NUM_ENG-1:0]    eng_key_valid,
  input  logic [NUM_ENG*24-1:0] eng_key
);

  localparam int SW_W = $clog2(START_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_LAUNCH = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // state_q is the observable FSM state for checkers bound to this block.
  state_t             state_q, state_d;
  logic [NUM_ENG-1:0] started, finished;
  logic [SW_W-1:0]    sw_cnt;

  logic [NUM_ENG-1:0] fin_now, to_fail, win;
  logic               win_any, fin_all, timeout_now;
  logic [23:0]        win_key;

  // Static key partition: engine i starts at key i and steps by NUM_ENG.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_base
    assign eng_base[24*g +: 24] = 24'(g);
  end
  assign eng_stride = 24'(NUM_ENG);

  assign rdy    = (state_q == S_IDLE);
  assign eng_en = {NUM_ENG{state_q == S_LAUNCH}};

  // Per-engine completion this cycle; lowest-index key-finder wins.
  always_comb begin
    timeout_now = (sw_cnt == SW_W'(1));
    fin_now     = started & eng_rdy & ~finished;
    // Engines that never dropped eng_rdy within the start window are retired.
    to_fail     = timeout_now ? (~started & ~finished & eng_rdy) : '0;
    win         = fin_now & eng_key_valid;
    win_any     = |win;
    fin_all     = &(finished | fin_now | to_fail);
    win_key     = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (win[i]) win_key = eng_key[24*i +: 24];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_DRAIN;
      S_DRAIN:  if (&eng_rdy) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN:    if (win_any || fin_all) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      cycles    <= '0;
      started   <= '0;
      finished  <= '0;
      sw_cnt    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            key_valid <= 1'b0;
            err       <= 1'b0;
            cycles    <= '0;
          end
        end
        S_LAUNCH: begin
          started  <= '0;
          finished <= '0;
          sw_cnt   <= SW_W'(START_WAIT);
        end
        S_RUN: begin
          if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
          if (sw_cnt != '0) sw_cnt <= sw_cnt - SW_W'(1);
          started  <= started | ~eng_rdy;
          finished <= finished | fin_now | to_fail;
          if (|to_fail) err <= 1'b1;
          if (win_any) begin
            key       <= win_key;
            key_valid <= 1'b1;
          end else if (fin_all) begin
            key       <= '0;
            key_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
